// File: rtl/evm_ballot_controller.sv
// evm_ballot_controller
//   Sits between the raw voting-machine push-buttons and the per-candidate
//   vote counters. Every button is synchronised and debounced. One officer
//   ballot press arms exactly one vote. The three candidate buttons are
//   arbitrated into a single-cycle one-hot cast pulse. Result display is
//   gated until the poll is closed.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a ballot (arm) or close press
//   ARMED   | one vote may be cast; timeout timer running
//   RELEASE | vote cast, waiting for all candidate buttons to be released
//   CLOSED  | poll closed, results shown, everything ignored until reset
//
// Ports
//   clk, reset      : system clock, synchronous active-high reset
//   ballot, close   : raw officer buttons (arm / close poll)
//   p1, p2, p3      : raw candidate buttons
//   vote_o[2:0]     : one-hot cast pulse, bit0 = candidate 1
//   clr_o           : counter clear, first cycle after reset release
//   total_o[7:0]    : ballots cast, saturating at 255
//   ready_led       : high in ARMED
//   busy_led        : high in RELEASE
//   conflict_o      : multiple-press lockout active
//   timeout_o       : single-cycle pulse when an arm expires
//   full_o          : total_o == 255
//   show_en         : high in CLOSED
module evm_ballot_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ballot,
  input  logic       close,
  input  logic       p1,
  input  logic       p2,
  input  logic       p3,
  output logic [2:0] vote_o,
  output logic       clr_o,
  output logic [7:0] total_o,
  output logic       ready_led,
  output logic       busy_led,
  output logic       conflict_o,
  output logic       timeout_o,
  output logic       full_o,
  output logic       show_en
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [DB_W-1:0] DB_LIMIT = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [TM_W-1:0] TM_LOAD  = TM_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RELEASE, S_CLOSED} state_t;

  // button index: 0 ballot, 1 close, 2 p1, 3 p2, 4 p3
  logic [4:0]      raw;
  logic [4:0]      sync1_q, sync2_q;
  logic [4:0]      db_q, db_d, db_prev_q;
  logic [DB_W-1:0] dcnt_q [5];
  logic [DB_W-1:0] dcnt_d [5];

  state_t          state_q, state_d;
  logic [TM_W-1:0] tmr_q, tmr_d;
  logic            lock_q, lock_d;
  logic [2:0]      vote_q, vote_d;
  logic [7:0]      total_q, total_d;
  logic            timeout_q, timeout_d;
  logic            clr_q, rst_seen_q;

  logic [4:0] rise;
  logic [2:0] cand;
  logic       cand_one, cand_multi, full;

  assign raw = {p3, p2, p1, close, ballot};

  // The flip fires on the edge after the count has reached the limit, so a
  // level must disagree with db for DEBOUNCE_CYCLES+1 consecutive samples.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 5; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DB_LIMIT) db_d[i] = sync2_q[i];
        else                       dcnt_d[i] = dcnt_q[i] + DB_W'(1);
      end
    end
  end

  assign rise       = db_q & ~db_prev_q;
  assign cand       = db_q[4:2];
  assign cand_one   = (cand == 3'b001) || (cand == 3'b010) || (cand == 3'b100);
  assign cand_multi = (cand != 3'b000) && !cand_one;
  assign full       = (total_q == 8'hFF);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    lock_d    = lock_q;
    vote_d    = 3'b000;
    total_d   = total_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise[1]) begin
          state_d = S_CLOSED;
        end else if (rise[0] && !full) begin
          state_d = S_ARMED;
          tmr_d   = TM_LOAD;
        end
      end
      S_ARMED: begin
        if (cand_one && !lock_q) begin
          vote_d  = cand;
          total_d = full ? total_q : total_q + 8'd1;
          state_d = S_RELEASE;
        end else begin
          if (cand_multi)              lock_d = 1'b1;
          else if (cand == 3'b000)     lock_d = 1'b0;
          // expiry overrides any lockout update on the same edge
          if (tmr_q == '0) begin
            timeout_d = 1'b1;
            lock_d    = 1'b0;
            state_d   = S_IDLE;
          end else begin
            tmr_d = tmr_q - TM_W'(1);
          end
        end
      end
      S_RELEASE: begin
        if (cand == 3'b000) state_d = S_IDLE;
      end
      S_CLOSED: begin
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      db_prev_q  <= '0;
      for (int i = 0; i < 5; i++) dcnt_q[i] <= '0;
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      lock_q     <= 1'b0;
      vote_q     <= 3'b000;
      total_q    <= 8'd0;
      timeout_q  <= 1'b0;
      clr_q      <= 1'b0;
      rst_seen_q <= 1'b1;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      db_prev_q  <= db_q;
      for (int i = 0; i < 5; i++) dcnt_q[i] <= dcnt_d[i];
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      lock_q     <= lock_d;
      vote_q     <= vote_d;
      total_q    <= total_d;
      timeout_q  <= timeout_d;
      clr_q      <= rst_seen_q;
      rst_seen_q <= 1'b0;
    end
  end

  assign vote_o     = vote_q;
  assign clr_o      = clr_q;
  assign total_o    = total_q;
  assign ready_led  = (state_q == S_ARMED);
  assign busy_led   = (state_q == S_RELEASE);
  assign show_en    = (state_q == S_CLOSED);
  assign conflict_o = lock_q;
  assign timeout_o  = timeout_q;
  assign full_o     = full;

endmodule
